// File: rtl/circuit2_driver.sv
// Transaction front end for the circuit2 signed datapath: drives operand triples, captures x/z into an in-order result FIFO.
// Optional golden-model checking with a sticky mismatch flag is enabled by defining CIRCUIT2_DRV_CHECK_EN.
module circuit2_driver #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic [WIDTH-1:0] dp_c,
    input  logic [WIDTH-1:0] dp_x,
    input  logic [WIDTH-1:0] dp_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_z,
    output logic             busy
`ifdef CIRCUIT2_DRV_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] mem_x [DEPTH];
    logic [WIDTH-1:0] mem_z [DEPTH];
    logic [WIDTH-1:0] head_x_nxt;
    logic [WIDTH-1:0] head_z_nxt;
    logic             accept;
    logic             push;
    logic             pop;

    // Handshakes, FIFO bookkeeping and the next head value for the registered outputs
    always_comb begin
        accept     = (state == IDLE) && in_valid && in_ready;
        push       = (state == CAPTURE);
        pop        = out_valid && out_ready;
        count_nxt  = count + CW'(push) - CW'(pop);
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        state_nxt  = state;
        case (state)
            IDLE:    if (accept) state_nxt = DRIVE;
            DRIVE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        head_x_nxt = mem_x[rd_ptr_nxt];
        head_z_nxt = mem_z[rd_ptr_nxt];
        // The entry being pushed becomes the head when nothing older remains
        if (push && (count == CW'(pop))) begin
            head_x_nxt = dp_x;
            head_z_nxt = dp_z;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_c      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_z     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (accept) begin
                dp_a <= in_a;
                dp_b <= in_b;
                dp_c <= in_c;
            end
            in_ready  <= (state_nxt == IDLE) && (count_nxt < CW'(DEPTH));
            out_valid <= (count_nxt != '0);
            out_x     <= head_x_nxt;
            out_z     <= head_z_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

    // Result storage needs no reset; count and pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= dp_x;
            mem_z[wr_ptr] <= dp_z;
        end
    end

`ifdef CIRCUIT2_DRV_CHECK_EN
    logic signed [WIDTH-1:0] ga, gb, gc, gd, ge, gf, gg, gh, gx, gz;
    logic                    glt, geq;

    // Reference circuit2 evaluated on the operands currently held on dp_a/b/c
    always_comb begin
        ga  = $signed(dp_a);
        gb  = $signed(dp_b);
        gc  = $signed(dp_c);
        gd  = ga + gb;
        ge  = ga + gc;
        gf  = ga - gb;
        glt = (gd < ge);
        geq = (gd == ge);
        gg  = glt ? gd : ge;
        gh  = geq ? gg : gf;
        gx  = glt ? (gg << 1) : gg;
        gz  = geq ? (gh >>> 1) : gh;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mismatch <= 1'b0;
        end else if (push && ((dp_x != $unsigned(gx)) || (dp_z != $unsigned(gz)))) begin
            mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_circuit2_driver.sv
// Scoreboard bench for circuit2_driver with a behavioural circuit2 datapath (one register stage) attached.
// Define CIRCUIT2_DRV_CHECK_EN to also exercise the mismatch flag.
module tb_circuit2_driver;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b, in_c;
    logic [WIDTH-1:0] dp_a, dp_b, dp_c;
    logic [WIDTH-1:0] dp_x, dp_z;
    logic [WIDTH-1:0] dpx_r, dpz_r;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x, out_z;
    logic             busy;
    logic             flip;
`ifdef CIRCUIT2_DRV_CHECK_EN
    logic             mismatch;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_x_q [$];
    logic [WIDTH-1:0] exp_z_q [$];

    always #5 clk = ~clk;

    circuit2_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_c      (dp_c),
        .dp_x      (dp_x),
        .dp_z      (dp_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_z     (out_z),
`ifdef CIRCUIT2_DRV_CHECK_EN
        .mismatch  (mismatch),
`endif
        .busy      (busy)
    );

    function automatic logic [2*WIDTH-1:0] golden(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic [WIDTH-1:0] c);
        logic signed [WIDTH-1:0] d, e, f, g, h, x, z;
        logic lt, eq;
        d  = $signed(a) + $signed(b);
        e  = $signed(a) + $signed(c);
        f  = $signed(a) - $signed(b);
        lt = (d < e);
        eq = (d == e);
        g  = lt ? d : e;
        h  = eq ? g : f;
        x  = lt ? (g << 1) : g;
        z  = eq ? (h >>> 1) : h;
        return {x, z};
    endfunction

    // Behavioural circuit2: output registers capture one edge after operands change
    always_ff @(posedge clk) begin
        {dpx_r, dpz_r} <= golden(dp_a, dp_b, dp_c);
    end
    assign dp_x = dpx_r ^ {{(WIDTH-1){1'b0}}, flip};
    assign dp_z = dpz_r;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Consumer side: every handshaken head is compared with the oldest expected result
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_x_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                check("out_x", out_x, exp_x_q.pop_front());
                check("out_z", out_z, exp_z_q.pop_front());
            end
        end
    end

    // Offer one triple and wait (bounded) for the accept edge; returns 1 ns after that edge
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                        input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] ez, input bit keep);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                if (keep) begin
                    exp_x_q.push_back(ex);
                    exp_z_q.push_back(ez);
                end
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, rc;
        logic [2*WIDTH-1:0] g;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
        out_ready = 1'b1; flip = 1'b0;
        tick(2);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dp_a", dp_a, 32'd0);
        check("rst_out_x", out_x, 32'd0);
`ifdef CIRCUIT2_DRV_CHECK_EN
        check("rst_mismatch", 32'(mismatch), 32'd0);
`endif
        @(negedge clk); rst = 1'b1;
        tick(1);

        // Basic vector with latency check: out_valid rises after edge k+2
        send(32'd5, 32'd3, 32'd1, 32'd6, 32'd2, 1'b1);
        check("dp_a_after_accept", dp_a, 32'd5);
        check("busy_in_drive", 32'(busy), 32'd1);
        check("in_ready_in_drive", 32'(in_ready), 32'd0);
        tick(1);
        check("lat_valid_k1", 32'(out_valid), 32'd0);
        tick(1);
        check("lat_valid_k2", 32'(out_valid), 32'd1);
        tick(2);

        send(32'd1, 32'd2, 32'd2, 32'd3, 32'd1, 1'b1);
        send(32'd0, 32'd1, 32'd5, 32'd2, 32'hFFFF_FFFF, 1'b1);
        send(32'hFFFF_FFF8, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rc = (i % 2 == 0) ? rb : $urandom;
            g = golden(ra, rb, rc);
            send(ra, rb, rc, g[2*WIDTH-1:WIDTH], g[WIDTH-1:0], 1'b1);
        end
        tick(4);

        // Backpressure: four results fill the FIFO, a fifth offer stalls
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            g = golden(32'(i + 10), 32'(i), 32'(3 * i));
            send(32'(i + 10), 32'(i), 32'(3 * i), g[2*WIDTH-1:WIDTH], g[WIDTH-1:0], 1'b1);
        end
        tick(3);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        in_a = 32'd7; in_b = 32'd9; in_c = 32'd2; in_valid = 1'b1;
        tick(4);
        check("stall_busy", 32'(busy), 32'd0);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        g = golden(32'd7, 32'd9, 32'd2);
        send(32'd7, 32'd9, 32'd2, g[2*WIDTH-1:WIDTH], g[WIDTH-1:0], 1'b1);
        tick(8);
        check("drain_queue_empty", 32'(exp_x_q.size()), 32'd0);

        // Reset during DRIVE drops the transaction
        send(32'd4, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        #2;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_dp_a", dp_a, 32'd0);
        check("mid_rst_out_x", out_x, 32'd0);
        @(negedge clk); rst = 1'b1;
        tick(6);
        check("post_rst_no_result", 32'(out_valid), 32'd0);

`ifdef CIRCUIT2_DRV_CHECK_EN
        // Corrupt datapath x bit 0: flag sets after capture and holds until reset
        flip = 1'b1;
        send(32'd5, 32'd3, 32'd1, 32'd7, 32'd2, 1'b1);
        tick(3);
        flip = 1'b0;
        check("mismatch_set", 32'(mismatch), 32'd1);
        tick(5);
        check("mismatch_held", 32'(mismatch), 32'd1);
        @(negedge clk); rst = 1'b0;
        #2;
        check("mismatch_cleared", 32'(mismatch), 32'd0);
        @(negedge clk); rst = 1'b1;
        tick(2);
`endif

        check("final_queue_empty", 32'(exp_x_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
